dtpu_csr_bank: RTL and testbench

//  Responder-side CSR register bank for dtpu_core's CSR port: dtpu_core initiates

---
 rtl/dtpu_csr_bank.sv | 126 ++++++++++++
 tb/tb_dtpu_csr_bank.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dtpu_csr_bank.sv
// CSR register bank between the PS host port and dtpu_core's BRAM-style CSR port.
// Holds config, sticky status, a saturating busy-cycle counter and a run-time config lock.
module dtpu_csr_bank #(
  parameter int unsigned DATA_WIDTH_CSR   = 64,
  parameter int unsigned ADDRESS_SIZE_CSR = 32,
  parameter logic [3:0]  PREC_RESET       = 4'h1
) (
  input  logic                        clk,
  input  logic                        aresetn,
  input  logic [ADDRESS_SIZE_CSR-1:0] csr_address,
  input  logic                        csr_ce,
  input  logic                        csr_we,
  input  logic [DATA_WIDTH_CSR-1:0]   csr_din,
  input  logic                        csr_reset,
  output logic [DATA_WIDTH_CSR-1:0]   csr_dout,
  input  logic                        cs_idle,
  input  logic                        cs_done,
  input  logic [2:0]                  h_addr,
  input  logic                        h_wr,
  input  logic                        h_rd,
  input  logic [DATA_WIDTH_CSR-1:0]   h_wdata,
  output logic [DATA_WIDTH_CSR-1:0]   h_rdata,
  output logic                        h_rvalid
);

  localparam logic [2:0] IdxPrec   = 3'd0;
  localparam logic [2:0] IdxFpMode = 3'd1;
  localparam logic [2:0] IdxCtrl   = 3'd2;
  localparam logic [2:0] IdxStatus = 3'd3;
  localparam logic [2:0] IdxCycles = 3'd4;
  localparam logic [2:0] IdxNone   = 3'd7;

  logic [3:0]                prec_q, prec_d;
  logic [3:0]                fp_mode_q, fp_mode_d;
  logic [1:0]                ctrl_q, ctrl_d;
  logic [7:0]                status_q, status_d;
  logic [DATA_WIDTH_CSR-1:0] cycles_q, cycles_d;

  logic [DATA_WIDTH_CSR-1:0] rd_map [8];
  logic [2:0]                core_idx;
  logic                      core_rd, core_wr;
  logic                      h_wr_prec, h_wr_fp, h_wr_ctrl, h_wr_status, h_wr_cycles;
  logic [7:0]                status_set;
  logic                      soft_clear;

  logic unused_bits;
  assign unused_bits = ^{csr_din[DATA_WIDTH_CSR-1:8], csr_din[3:0], h_wdata[DATA_WIDTH_CSR-1:8]};

  // Any nonzero address bit above [2:0] aliases to an unmapped slot.
  assign core_idx = (csr_address[ADDRESS_SIZE_CSR-1:3] == '0) ? csr_address[2:0] : IdxNone;
  assign core_rd  = csr_ce & ~csr_we;
  assign core_wr  = csr_ce & csr_we;

  assign h_wr_prec   = h_wr & (h_addr == IdxPrec);
  assign h_wr_fp     = h_wr & (h_addr == IdxFpMode);
  assign h_wr_ctrl   = h_wr & (h_addr == IdxCtrl);
  assign h_wr_status = h_wr & (h_addr == IdxStatus);
  assign h_wr_cycles = h_wr & (h_addr == IdxCycles);
  assign soft_clear  = ctrl_q[1];

  always_comb begin
    for (int i = 0; i < 8; i++) rd_map[i] = '0;
    rd_map[IdxPrec]   = DATA_WIDTH_CSR'(prec_q);
    rd_map[IdxFpMode] = DATA_WIDTH_CSR'(fp_mode_q);
    rd_map[IdxCtrl]   = DATA_WIDTH_CSR'(ctrl_q);
    rd_map[IdxStatus] = DATA_WIDTH_CSR'(status_q);
    rd_map[IdxCycles] = cycles_q;
  end

  always_comb begin
    prec_d    = prec_q;
    fp_mode_d = fp_mode_q;
    if (h_wr_prec && cs_idle) prec_d = h_wdata[3:0];
    if (h_wr_fp && cs_idle) fp_mode_d = h_wdata[3:0];

    ctrl_d = ctrl_q;
    if (soft_clear) ctrl_d[1] = 1'b0;
    if (h_wr_ctrl) ctrl_d = h_wdata[1:0];

    status_set    = '0;
    status_set[0] = cs_done;
    status_set[1] = (h_wr_prec | h_wr_fp) & ~cs_idle;
    status_set[2] = core_wr & (core_idx != IdxStatus);
    if (core_wr && core_idx == IdxStatus) status_set[7:4] = csr_din[7:4];

    // Sets win over a same-cycle W1C; soft_clear wipes everything.
    status_d = status_q;
    if (h_wr_status) status_d = status_d & ~h_wdata[7:0];
    status_d = status_d | status_set;
    if (soft_clear) status_d = '0;

    cycles_d = cycles_q;
    if (soft_clear || h_wr_cycles) begin
      cycles_d = '0;
    end else if (ctrl_q[0] && !cs_idle && !(&cycles_q)) begin
      cycles_d = cycles_q + DATA_WIDTH_CSR'(1);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      prec_q    <= PREC_RESET;
      fp_mode_q <= '0;
      ctrl_q    <= 2'b01;
      status_q  <= '0;
      cycles_q  <= '0;
      csr_dout  <= '0;
      h_rdata   <= '0;
      h_rvalid  <= 1'b0;
    end else begin
      prec_q    <= prec_d;
      fp_mode_q <= fp_mode_d;
      ctrl_q    <= ctrl_d;
      status_q  <= status_d;
      cycles_q  <= cycles_d;
      if (csr_reset) begin
        csr_dout <= '0;
      end else if (core_rd) begin
        csr_dout <= rd_map[core_idx];
      end
      h_rvalid <= h_rd;
      if (h_rd) h_rdata <= rd_map[h_addr];
    end
  end

endmodule

// File: tb/tb_dtpu_csr_bank.sv
// Directed bench for dtpu_csr_bank: expected read data is queued at issue time and
// checked by a monitor when h_rvalid or a tracked core read presents data.
module tb_dtpu_csr_bank;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [31:0] csr_address;
  logic        csr_ce, csr_we, csr_reset;
  logic [63:0] csr_din, csr_dout;
  logic        cs_idle, cs_done;
  logic [2:0]  h_addr;
  logic        h_wr, h_rd, h_rvalid;
  logic [63:0] h_wdata, h_rdata;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] h_exp[$];
  logic [63:0] c_exp[$];
  logic        c_pend = 1'b0;

  localparam logic [63:0] AllOnes = 64'hFFFF_FFFF_FFFF_FFFF;

  dtpu_csr_bank dut (
    .clk(clk), .aresetn(aresetn), .csr_address(csr_address), .csr_ce(csr_ce),
    .csr_we(csr_we), .csr_din(csr_din), .csr_reset(csr_reset), .csr_dout(csr_dout),
    .cs_idle(cs_idle), .cs_done(cs_done), .h_addr(h_addr), .h_wr(h_wr), .h_rd(h_rd),
    .h_wdata(h_wdata), .h_rdata(h_rdata), .h_rvalid(h_rvalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Tracks which edges load csr_dout so the monitor knows when to compare.
  always @(posedge clk) c_pend <= aresetn && (csr_reset || (csr_ce && !csr_we));

  always @(negedge clk) begin
    if (h_rvalid) begin
      if (h_exp.size() == 0) check("h_unexpected_rvalid", 64'd1, 64'd0);
      else check("h_rdata", h_rdata, h_exp.pop_front());
    end
    if (c_pend) begin
      if (c_exp.size() == 0) check("c_unexpected_read", 64'd1, 64'd0);
      else check("csr_dout", csr_dout, c_exp.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_rd(input logic [2:0] idx, input logic [63:0] exp);
    h_addr = idx; h_rd = 1'b1; h_exp.push_back(exp);
    step();
    h_rd = 1'b0;
  endtask

  task automatic host_wr(input logic [2:0] idx, input logic [63:0] data);
    h_addr = idx; h_wdata = data; h_wr = 1'b1;
    step();
    h_wr = 1'b0;
  endtask

  task automatic core_rd(input logic [31:0] addr, input logic [63:0] exp);
    csr_address = addr; csr_ce = 1'b1; csr_we = 1'b0; c_exp.push_back(exp);
    step();
    csr_ce = 1'b0;
  endtask

  task automatic core_wr(input logic [31:0] addr, input logic [63:0] data);
    csr_address = addr; csr_din = data; csr_ce = 1'b1; csr_we = 1'b1;
    step();
    csr_ce = 1'b0; csr_we = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0; csr_address = '0; csr_ce = 0; csr_we = 0; csr_din = '0; csr_reset = 0;
    cs_idle = 1'b1; cs_done = 0; h_addr = '0; h_wr = 0; h_rd = 0; h_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_csr_dout", csr_dout, 64'd0);
    check("rst_h_rdata", h_rdata, 64'd0);
    check("rst_h_rvalid", {63'd0, h_rvalid}, 64'd0);
    aresetn = 1'b1;
    step();

    // Reset values via both ports
    core_rd(32'd0, 64'd1);
    core_rd(32'd1, 64'd0);
    core_rd(32'd6, 64'd0);
    host_rd(3'd0, 64'd1);
    host_rd(3'd1, 64'd0);
    host_rd(3'd2, 64'd1);
    host_rd(3'd3, 64'd0);
    host_rd(3'd4, 64'd0);
    host_rd(3'd7, 64'd0);

    // Host write while idle, core read same cycle sees old value
    h_addr = 3'd0; h_wdata = 64'd2; h_wr = 1'b1;
    csr_address = 32'd0; csr_ce = 1'b1; c_exp.push_back(64'd1);
    step();
    h_wr = 1'b0; csr_ce = 1'b0;
    core_rd(32'd0, 64'd2);
    host_rd(3'd0, 64'd2);
    // Same-cycle host read/write: old value returned; upper bits dropped
    h_addr = 3'd1; h_wdata = 64'hFF7; h_wr = 1'b1; h_rd = 1'b1; h_exp.push_back(64'd0);
    step();
    h_wr = 1'b0; h_rd = 1'b0;
    host_rd(3'd1, 64'd7);

    // Lock violation while running, then W1C
    cs_idle = 1'b0;
    host_wr(3'd1, 64'd3);
    host_rd(3'd1, 64'd7);
    host_rd(3'd3, 64'd2);
    host_wr(3'd3, 64'd2);
    host_rd(3'd3, 64'd0);
    cs_idle = 1'b1;
    host_wr(3'd4, 64'd0);
    host_rd(3'd4, 64'd0);

    // Cycle counter, saturation, soft clear
    cs_idle = 1'b0;
    repeat (10) step();
    cs_idle = 1'b1;
    host_rd(3'd4, 64'd10);
    core_wr(32'd3, 64'hFFFF);
    host_rd(3'd3, 64'hF0);
    cs_idle = 1'b0;
    force dut.cycles_q = AllOnes;
    step();
    step();
    release dut.cycles_q;
    step();
    host_rd(3'd4, AllOnes);
    cs_idle = 1'b1;
    host_wr(3'd2, 64'd3);
    step();
    host_rd(3'd4, 64'd0);
    host_rd(3'd3, 64'd0);
    host_rd(3'd2, 64'd1);

    // Done set beats W1C; illegal core write; core flags
    cs_done = 1'b1; h_addr = 3'd3; h_wdata = 64'd1; h_wr = 1'b1;
    step();
    cs_done = 1'b0; h_wr = 1'b0;
    host_rd(3'd3, 64'd1);
    core_wr(32'd0, 64'd5);
    host_rd(3'd3, 64'd5);
    core_rd(32'd0, 64'd2);
    core_wr(32'd3, 64'hA0);
    host_rd(3'd3, 64'hA5);
    core_rd(32'h8, 64'd0);
    host_wr(3'd5, AllOnes);
    host_rd(3'd5, 64'd0);
    core_rd(32'd3, 64'hA5);
    csr_reset = 1'b1; csr_ce = 1'b1; csr_address = 32'd0; c_exp.push_back(64'd0);
    step();
    csr_reset = 1'b0; csr_ce = 1'b0;
    core_rd(32'd1, 64'd7);
    step();
    step();
    check("csr_dout_hold", csr_dout, 64'd7);

    // Asynchronous reset mid-run
    cs_idle = 1'b0;
    repeat (3) step();
    core_rd(32'd0, 64'd2);
    host_rd(3'd4, 64'd4);
    h_addr = 3'd0; h_rd = 1'b1;
    step();
    h_rd = 1'b0;
    check("rvalid_before_reset", {63'd0, h_rvalid}, 64'd1);
    aresetn = 1'b0;
    #1;
    check("areset_h_rvalid", {63'd0, h_rvalid}, 64'd0);
    check("areset_csr_dout", csr_dout, 64'd0);
    check("areset_h_rdata", h_rdata, 64'd0);
    cs_idle = 1'b1;
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    step();
    core_rd(32'd0, 64'd1);
    host_rd(3'd4, 64'd0);
    host_rd(3'd3, 64'd0);
    host_rd(3'd1, 64'd0);

    repeat (3) step();
    check("h_queue_drained", 64'(h_exp.size()), 64'd0);
    check("c_queue_drained", 64'(c_exp.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
